// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Handshaked sequential ALU. Accepts one operation over a
//            valid/ready input port and returns a registered result over a
//            valid/ready output port. Single-cycle ops finish in one clock;
//            MUL is an iterative shift-add taking WIDTH clocks.
// Ports    : clk        - clock, rising edge
//            rst_n      - synchronous active-low reset
//            in_valid   - operation offered
//            in_ready   - operation can be accepted this cycle
//            code       - 4-bit opcode, sampled on accept
//            x, y       - WIDTH-bit operands, sampled on accept
//            out_valid  - z / cmp_flag / zero_flag hold a result
//            out_ready  - consumer takes the result
//            z          - result register
//            cmp_flag   - compare flag register (CLT/CEQ/NOP only)
//            zero_flag  - registered (z == 0)
//            busy       - MUL iteration in progress
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 32  // must be at least 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       code,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             cmp_flag,
  output logic             zero_flag,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] c_OP_ADD = 4'b0000;
  localparam logic [3:0] c_OP_SUB = 4'b0001;
  localparam logic [3:0] c_OP_MUL = 4'b0010;
  localparam logic [3:0] c_OP_AND = 4'b0011;
  localparam logic [3:0] c_OP_OR  = 4'b0100;
  localparam logic [3:0] c_OP_XOR = 4'b0101;
  localparam logic [3:0] c_OP_NOT = 4'b0110;
  localparam logic [3:0] c_OP_MAX = 4'b0111;
  localparam logic [3:0] c_OP_SLL = 4'b1000;
  localparam logic [3:0] c_OP_SRL = 4'b1001;
  localparam logic [3:0] c_OP_CLT = 4'b1010;
  localparam logic [3:0] c_OP_CEQ = 4'b1011;
  localparam logic [3:0] c_OP_MIN = 4'b1100;
  localparam logic [3:0] c_OP_SRA = 4'b1101;

  localparam logic [WIDTH-1:0] c_width_v  = WIDTH'(WIDTH);
  localparam logic [SHW-1:0]   c_cnt_last = SHW'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  // Registered state
  state_t           r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_z;
  logic             r_cmp;
  logic             r_zero;
  logic             r_out_valid;

  // Next-state values
  state_t           w_state_nx;
  logic [WIDTH-1:0] w_mcand_nx;
  logic [WIDTH-1:0] w_mplier_nx;
  logic [WIDTH-1:0] w_acc_nx;
  logic [SHW-1:0]   w_cnt_nx;
  logic [WIDTH-1:0] w_z_nx;
  logic             w_cmp_nx;
  logic             w_zero_nx;
  logic             w_out_valid_nx;

  // Single-cycle ALU result
  logic [WIDTH-1:0] w_alu_z;
  logic             w_alu_cmp;
  logic [SHW-1:0]   w_shamt;
  logic             w_y_big;
  logic [WIDTH-1:0] w_sra;
  logic [WIDTH-1:0] w_acc_sum;
  logic             w_in_ready;
  logic             w_accept;

  assign w_in_ready = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;

  // Shifts by WIDTH or more saturate rather than wrap the amount
  assign w_shamt   = y[SHW-1:0];
  assign w_y_big   = (y >= c_width_v);
  assign w_sra     = WIDTH'($signed(x) >>> w_shamt);
  assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_comb begin
    w_alu_z   = '0;
    w_alu_cmp = r_cmp;
    case (code)
      c_OP_ADD: w_alu_z = x + y;
      c_OP_SUB: w_alu_z = x - y;
      c_OP_AND: w_alu_z = x & y;
      c_OP_OR:  w_alu_z = x | y;
      c_OP_XOR: w_alu_z = x ^ y;
      c_OP_NOT: w_alu_z = ~x;
      c_OP_MAX: w_alu_z = (x > y) ? x : y;
      c_OP_MIN: w_alu_z = (x < y) ? x : y;
      c_OP_SLL: w_alu_z = w_y_big ? '0 : (x << w_shamt);
      c_OP_SRL: w_alu_z = w_y_big ? '0 : (x >> w_shamt);
      c_OP_SRA: w_alu_z = w_y_big ? {WIDTH{x[WIDTH-1]}} : w_sra;
      c_OP_CLT: w_alu_cmp = (x < y);
      c_OP_CEQ: w_alu_cmp = (x == y);
      c_OP_MUL: w_alu_z = '0;  // handled by the iterative path
      default:  w_alu_cmp = 1'b0;  // 1110/1111 NOP clears the flag
    endcase
  end

  // Next-state / datapath control
  always_comb begin
    w_state_nx     = r_state;
    w_mcand_nx     = r_mcand;
    w_mplier_nx    = r_mplier;
    w_acc_nx       = r_acc;
    w_cnt_nx       = r_cnt;
    w_z_nx         = r_z;
    w_cmp_nx       = r_cmp;
    w_zero_nx      = r_zero;
    w_out_valid_nx = r_out_valid;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (code == c_OP_MUL) begin
            w_state_nx     = S_MUL;
            w_mcand_nx     = x;
            w_mplier_nx    = y;
            w_acc_nx       = '0;
            w_cnt_nx       = '0;
            // Accept implies any previous result is consumed now
            w_out_valid_nx = 1'b0;
          end else begin
            w_z_nx         = w_alu_z;
            w_zero_nx      = (w_alu_z == '0);
            w_cmp_nx       = w_alu_cmp;
            w_out_valid_nx = 1'b1;
          end
        end else if (r_out_valid && out_ready) begin
          w_out_valid_nx = 1'b0;
        end
      end
      S_MUL: begin
        w_acc_nx    = w_acc_sum;
        w_mcand_nx  = r_mcand << 1;
        w_mplier_nx = r_mplier >> 1;
        w_cnt_nx    = r_cnt + SHW'(1);
        if (r_cnt == c_cnt_last) begin
          // Last iteration: the sum including this step is the product
          w_state_nx     = S_IDLE;
          w_z_nx         = w_acc_sum;
          w_zero_nx      = (w_acc_sum == '0);
          w_out_valid_nx = 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_z         <= '0;
      r_cmp       <= 1'b0;
      r_zero      <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_mcand     <= w_mcand_nx;
      r_mplier    <= w_mplier_nx;
      r_acc       <= w_acc_nx;
      r_cnt       <= w_cnt_nx;
      r_z         <= w_z_nx;
      r_cmp       <= w_cmp_nx;
      r_zero      <= w_zero_nx;
      r_out_valid <= w_out_valid_nx;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign z         = r_z;
  assign cmp_flag  = r_cmp;
  assign zero_flag = r_zero;
  assign busy      = (r_state == S_MUL);

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Self-checking bench for alu_seq (WIDTH=32). A transaction-level
//            reference model tracks the expected outputs every cycle; directed
//            sequences pin literal results; a randomized phase follows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    code = 4'd0;
  logic [W-1:0]  x = '0;
  logic [W-1:0]  y = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  z;
  logic          cmp_flag;
  logic          zero_flag;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .code(code), .x(x), .y(y),
    .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .cmp_flag(cmp_flag), .zero_flag(zero_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [W-1:0] m_z = '0;
  logic         m_cmp = 1'b0;
  logic         m_ov = 1'b0;
  int           m_left = 0;    // MUL cycles still to run
  logic [W-1:0] m_prod = '0;

  task automatic model_alu(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] r, inout logic f);
    logic [63:0] t;
    logic [63:0] p2;
    logic [W-1:0] ones;
    ones = '1;
    r = '0;
    p2 = (b < 32) ? (64'd1 << b) : 64'd0;
    case (c)
      4'd0:  begin t = {32'd0, a} + {32'd0, b}; r = t[31:0]; end
      4'd1:  begin t = {32'd0, a} + 64'h1_0000_0000 - {32'd0, b}; r = t[31:0]; end
      4'd3:  r = a & b;
      4'd4:  r = a | b;
      4'd5:  r = a ^ b;
      4'd6:  r = ~a;
      4'd7:  r = (a >= b) ? a : b;
      4'd8:  begin t = {32'd0, a} * p2; r = (b >= 32) ? '0 : t[31:0]; end
      4'd9:  r = (b >= 32) ? '0 : W'({32'd0, a} / p2);
      4'd10: f = (a < b);
      4'd11: f = (a == b);
      4'd12: r = (a <= b) ? a : b;
      4'd13: begin
        if (b >= 32) r = {W{a[W-1]}};
        else r = W'({32'd0, a} / p2) | (a[W-1] ? ~W'({32'd0, ones} / p2) : '0);
      end
      4'd14, 4'd15: f = 1'b0;
      default: r = '0;
    endcase
  endtask

  always @(posedge clk) begin
    logic [63:0] t;
    logic [W-1:0] r;
    logic f;
    bit rdy;
    if (!rst_n) begin
      m_z = '0; m_cmp = 1'b0; m_ov = 1'b0; m_left = 0;
    end else begin
      rdy = (m_left == 0) && (!m_ov || out_ready);
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin m_z = m_prod; m_ov = 1'b1; end
      end else if (in_valid && rdy) begin
        if (code == 4'd2) begin
          t = {32'd0, x} * {32'd0, y};
          m_prod = t[31:0];
          m_left = W;
          m_ov = 1'b0;
        end else begin
          f = m_cmp;
          model_alu(code, x, y, r, f);
          m_z = r; m_cmp = f; m_ov = 1'b1;
        end
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_in_ready",  W'(in_ready),  W'((m_left == 0) && (!m_ov || out_ready)));
      chk("m_out_valid", W'(out_valid), W'(m_ov));
      chk("m_busy",      W'(busy),      W'(m_left > 0));
      chk("m_z",         z,             m_z);
      chk("m_cmp",       W'(cmp_flag),  W'(m_cmp));
      chk("m_zero",      W'(zero_flag), W'(m_z == '0));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    int t;
    bit acc;
    in_valid = 1'b1; code = c; x = a; y = b;
    t = 0; acc = 1'b0;
    while (!acc) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      t++;
      if (!acc && t > 200) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic get(input string nm, input logic [W-1:0] ez, input logic ec);
    int t;
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 100) begin @(negedge clk); t++; end
    chk({nm, "_valid"}, W'(out_valid), 1);
    chk({nm, "_z"}, z, ez);
    chk({nm, "_cmp"}, W'(cmp_flag), W'(ec));
  endtask

  initial begin
    bit ok;
    // Reset then ADD
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_z", z, 0);
    chk("rst_flags", {29'd0, cmp_flag, zero_flag, out_valid}, 32'b010);
    chk("rst_busy_ready", {30'd0, busy, in_ready}, 32'b01);
    op(4'd0, 32'hFFFF_FFFF, 32'd1);
    get("add_wrap", 32'd0, 1'b0);
    chk("add_wrap_zero", W'(zero_flag), 1);

    // Full MUL: busy for exactly 32 cycles
    op(4'd2, 32'h0001_0003, 32'h0000_0005);
    ok = 1'b1;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (!busy || in_ready || out_valid) ok = 1'b0;
    end
    chk("mul_busy_window", W'(ok), 1);
    @(negedge clk);
    chk("mul_done_valid", {30'd0, out_valid, busy}, 32'b10);
    chk("mul_z", z, 32'h0005_000F);
    op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    get("mul_ff", 32'h0000_0001, 1'b0);

    // Compare and flag hold
    op(4'd10, 32'd3, 32'd7);  get("clt", 32'd0, 1'b1);
    op(4'd0, 32'd1, 32'd1);   get("add_hold", 32'd2, 1'b1);
    op(4'd11, 32'd5, 32'd6);  get("ceq", 32'd0, 1'b0);
    op(4'd10, 32'd1, 32'd9);  get("clt2", 32'd0, 1'b1);
    op(4'd15, 32'd4, 32'd4);  get("nop", 32'd0, 1'b0);

    // Shifts and new ops
    op(4'd13, 32'h8000_0000, 32'd4);  get("sra4", 32'hF800_0000, 1'b0);
    op(4'd13, 32'h8000_0000, 32'd40); get("sra40", 32'hFFFF_FFFF, 1'b0);
    op(4'd8, 32'd1, 32'd32);          get("sll32", 32'd0, 1'b0);
    op(4'd6, 32'd0, 32'd0);           get("not0", 32'hFFFF_FFFF, 1'b0);
    op(4'd12, 32'd9, 32'd4);          get("min", 32'd4, 1'b0);
    op(4'd7, 32'd9, 32'd4);           get("max", 32'd9, 1'b0);

    // Backpressure
    op(4'd0, 32'd4, 32'd5);
    out_ready = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (z !== 32'd9 || in_ready || !out_valid) ok = 1'b0;
    end
    chk("bp_stall", W'(ok), 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    op(4'd1, 32'd10, 32'd3);
    get("bp_sub", 32'd7, 1'b0);

    // Reset mid-MUL
    op(4'd2, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst", {29'd0, out_valid, busy, in_ready}, 32'b001);
    chk("midrst_z", z, 0);
    op(4'd0, 32'd2, 32'd3);
    get("post_rst_add", 32'd5, 1'b0);

    // Randomized phase, checked by the per-cycle model
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      rst_n     = ($urandom_range(0, 599) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      code      = 4'($urandom_range(0, 15));
      x         = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : $urandom;
      y         = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 40)) : $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
